// File: rtl/window_frame_scheduler_pkg.sv
// Shared definitions for the window frame scheduler: FSM state codes,
// counter width helpers and the parameter legality check.
package window_pkg;

   localparam logic [1:0] FILL = 2'd0;
   localparam logic [1:0] EMIT = 2'd1;
   localparam logic [1:0] HOP  = 2'd2;

   // Width of a window position (TUSER, RAM address).
   function automatic int idxWidth(input int windowSize);
      return $clog2(windowSize);
   endfunction

   // One extra bit so the count and idx counters can hold WINDOW_SIZE itself.
   function automatic int cntWidth(input int windowSize);
      return $clog2(windowSize) + 1;
   endfunction

   // Window must be a power of two of at least 4; hop must fit inside the window.
   function automatic bit paramsValid(input int windowSize, input int hopSize);
      return (windowSize >= 4) && ((windowSize & (windowSize - 1)) == 0) &&
             (hopSize >= 1) && (hopSize <= windowSize);
   endfunction

endpackage

// File: rtl/window_frame_scheduler_if.sv
// AXI-Stream style bundle used for both the sample input and the frame output.
interface window_frame_scheduler_if #(
   parameter int DATA_W = 16,
   parameter int USER_W = 8
);
   logic              TVALID;
   logic              TREADY;
   logic [DATA_W-1:0] TDATA;
   logic [USER_W-1:0] TUSER;
   logic              TLAST;

   modport master (output TVALID, TDATA, TUSER, TLAST, input TREADY);
   modport slave  (input TVALID, TDATA, TUSER, TLAST, output TREADY);
endinterface

// File: rtl/window_frame_scheduler_frame_ram.sv
// Simple dual-port sample buffer with a registered (1-cycle) read port.
// Contents are deliberately left unreset so it maps onto block RAM.
module frame_ram #(
   parameter int DEPTH  = 256,
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              wrEn_i,
   input  logic [ADDR_W-1:0] wrAddr_i,
   input  logic [WIDTH-1:0]  wrData_i,
   input  logic              rdEn_i,
   input  logic [ADDR_W-1:0] rdAddr_i,
   output logic [WIDTH-1:0]  rdData_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdData_q;

   // Write port: one incoming sample per accepted input beat.
   always_ff @(posedge clk_i) begin
      if (wrEn_i) mem_q[wrAddr_i] <= wrData_i;
   end

   // Read port: data appears the cycle after the address is issued.
   always_ff @(posedge clk_i) begin
      if (rdEn_i) rdData_q <= mem_q[rdAddr_i];
   end

   assign rdData_o = rdData_q;
endmodule

// File: rtl/window_frame_scheduler.sv
// Ring-buffers the incoming sample stream and, every HOP_SIZE samples, replays
// the latest WINDOW_SIZE samples oldest-first as one frame tagged with its
// window position.
module window_frame_scheduler
   import window_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 16,
   parameter int WINDOW_SIZE  = 256,
   parameter int HOP_SIZE     = 128
) (
   input  logic AXIS_ACLK,
   input  logic AXIS_ARESETN,
   input  logic ENABLE,
   window_frame_scheduler_if.slave  s_axis,
   window_frame_scheduler_if.master m_axis
);
   localparam int IDX_W = idxWidth(WINDOW_SIZE);
   localparam int CNT_W = cntWidth(WINDOW_SIZE);
   localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WINDOW_SIZE);
   localparam logic [CNT_W-1:0] HOP_CNT  = CNT_W'(HOP_SIZE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW_SIZE - 1);

   if (!paramsValid(WINDOW_SIZE, HOP_SIZE)) begin : g_badParams
      $error("window_frame_scheduler: illegal WINDOW_SIZE/HOP_SIZE combination");
   end

   logic [1:0]              state_q, state_d;
   logic [IDX_W-1:0]        wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0]        count_q, count_d, idx_q, idx_d, target, countInc;
   logic                    sReady_q;
   logic                    pipeValid_q;
   logic [IDX_W-1:0]        pipeIdx_q;
   logic                    outValid_q, outValid_d, outLast_q, outLast_d;
   logic [SAMPLE_WIDTH-1:0] outData_q, outData_d;
   logic [IDX_W-1:0]        outUser_q, outUser_d;
   logic                    skidValid_q, skidValid_d, skidLast_q, skidLast_d;
   logic [SAMPLE_WIDTH-1:0] skidData_q, skidData_d;
   logic [IDX_W-1:0]        skidUser_q, skidUser_d;
   logic [SAMPLE_WIDTH-1:0] ramData;
   logic [IDX_W-1:0]        rdAddr;
   logic [2:0]              occupancy;
   logic                    accept, pop, popLast, issue, pipeLast;
   logic                    unusedInputs;

   assign unusedInputs = ^{s_axis.TUSER, s_axis.TLAST};

   assign accept   = sReady_q & s_axis.TVALID;
   assign pop      = outValid_q & m_axis.TREADY;
   assign popLast  = pop & outLast_q;
   assign pipeLast = (pipeIdx_q == LAST_IDX);
   assign rdAddr   = wrPtr_q + idx_q[IDX_W-1:0];
   assign target   = (state_q == FILL) ? WIN_CNT : HOP_CNT;
   assign countInc = count_q + CNT_W'(1);

   // Beats in flight (RAM stage + output + skid) left after this cycle's pop.
   // A read is only issued when the result is guaranteed a slot to land in.
   assign occupancy = 3'(pipeValid_q) + 3'(outValid_q) + 3'(skidValid_q) - 3'(pop);
   assign issue     = (state_q == EMIT) && (idx_q < WIN_CNT) && (occupancy <= 3'd1);

   frame_ram #(
      .DEPTH (WINDOW_SIZE),
      .WIDTH (SAMPLE_WIDTH),
      .ADDR_W(IDX_W)
   ) u_frameRam (
      .clk_i   (AXIS_ACLK),
      .wrEn_i  (accept),
      .wrAddr_i(wrPtr_q),
      .wrData_i(s_axis.TDATA),
      .rdEn_i  (issue),
      .rdAddr_i(rdAddr),
      .rdData_o(ramData)
   );

   // Frame sequencing: count fresh samples in FILL/HOP, walk idx in EMIT.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      idx_d   = idx_q;
      wrPtr_d = accept ? (wrPtr_q + IDX_W'(1)) : wrPtr_q;
      case (state_q)
         FILL, HOP: begin
            if (!ENABLE) begin
               count_d = '0;
               state_d = FILL;
            end else if (accept) begin
               if (countInc == target) begin
                  count_d = '0;
                  state_d = EMIT;
               end else begin
                  count_d = countInc;
               end
            end
         end
         EMIT: begin
            if (issue) idx_d = idx_q + CNT_W'(1);
            if (popLast) begin
               idx_d   = '0;
               count_d = '0;
               state_d = ENABLE ? HOP : FILL;
            end
         end
         default: begin
            state_d = FILL;
            count_d = '0;
            idx_d   = '0;
         end
      endcase
   end

   // Output register plus skid entry: the head only changes when it is
   // consumed or empty, so a stalled beat holds still.
   always_comb begin
      outValid_d  = outValid_q;
      outData_d   = outData_q;
      outUser_d   = outUser_q;
      outLast_d   = outLast_q;
      skidValid_d = skidValid_q;
      skidData_d  = skidData_q;
      skidUser_d  = skidUser_q;
      skidLast_d  = skidLast_q;
      if (pop) begin
         if (skidValid_q) begin
            outData_d   = skidData_q;
            outUser_d   = skidUser_q;
            outLast_d   = skidLast_q;
            skidValid_d = pipeValid_q;
            skidData_d  = ramData;
            skidUser_d  = pipeIdx_q;
            skidLast_d  = pipeLast;
         end else if (pipeValid_q) begin
            outData_d = ramData;
            outUser_d = pipeIdx_q;
            outLast_d = pipeLast;
         end else begin
            outValid_d = 1'b0;
         end
      end else if (pipeValid_q) begin
         if (!outValid_q) begin
            outValid_d = 1'b1;
            outData_d  = ramData;
            outUser_d  = pipeIdx_q;
            outLast_d  = pipeLast;
         end else begin
            skidValid_d = 1'b1;
            skidData_d  = ramData;
            skidUser_d  = pipeIdx_q;
            skidLast_d  = pipeLast;
         end
      end
   end

   // State, pointers and the whole output path clear immediately on reset.
   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state_q     <= FILL;
         wrPtr_q     <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         sReady_q    <= 1'b0;
         pipeValid_q <= 1'b0;
         pipeIdx_q   <= '0;
         outValid_q  <= 1'b0;
         outData_q   <= '0;
         outUser_q   <= '0;
         outLast_q   <= 1'b0;
         skidValid_q <= 1'b0;
         skidData_q  <= '0;
         skidUser_q  <= '0;
         skidLast_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wrPtr_q     <= wrPtr_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         sReady_q    <= (state_d != EMIT);
         pipeValid_q <= issue;
         if (issue) pipeIdx_q <= idx_q[IDX_W-1:0];
         outValid_q  <= outValid_d;
         outData_q   <= outData_d;
         outUser_q   <= outUser_d;
         outLast_q   <= outLast_d;
         skidValid_q <= skidValid_d;
         skidData_q  <= skidData_d;
         skidUser_q  <= skidUser_d;
         skidLast_q  <= skidLast_d;
      end
   end

   assign s_axis.TREADY = sReady_q;
   assign m_axis.TVALID = outValid_q;
   assign m_axis.TDATA  = outData_q;
   assign m_axis.TUSER  = outUser_q;
   assign m_axis.TLAST  = outLast_q;
endmodule

// File: tb/tb_window_frame_scheduler.sv
// Randomised scoreboard bench for window_frame_scheduler. Two instances run
// side by side (HOP_SIZE 4 and 8, WINDOW_SIZE 8) under shared reset/ENABLE.
module tb_window_frame_scheduler;
   localparam int DW  = 16;
   localparam int WIN = 8;
   localparam int UW  = 3;

   typedef struct {
      int unsigned data;
      int unsigned user;
      bit          last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b1;
   int unsigned sValidPct = 100;
   int unsigned mReadyPct = 100;
   int errors = 0;
   int checks = 0;

   logic          mValidW [2];
   logic          mLastW  [2];
   logic          sReadyW [2];
   logic [DW-1:0] mDataW  [2];
   logic [UW-1:0] mUserW  [2];
   logic          mReadyW [2];
   int            pending [2];

   initial forever #5 clk = ~clk;

   // Compare and tally one observation.
   task automatic checkOutput(input string name, input longint unsigned actual, input longint unsigned expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Set traffic levels and ENABLE, then let the stream run for a while.
   task automatic applyStimulus(input int cycles, input int unsigned sv, input int unsigned mr, input bit en);
      sValidPct = sv;
      mReadyPct = mr;
      enable    = en;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   // Bounded wait for a given window position on instance 0's output.
   task automatic waitBeat(input int unsigned user, input bit needPop, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (mValidW[0] && (mUserW[0] == UW'(user)) && (!needPop || mReadyW[0])) seen = 1'b1;
      end
      checkOutput(name, seen, 1);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int HOP = (g == 0) ? 4 : 8;

      window_frame_scheduler_if #(.DATA_W(DW), .USER_W(UW)) sIf ();
      window_frame_scheduler_if #(.DATA_W(DW), .USER_W(UW)) mIf ();

      window_frame_scheduler #(
         .SAMPLE_WIDTH(DW),
         .WINDOW_SIZE (WIN),
         .HOP_SIZE    (HOP)
      ) dut (
         .AXIS_ACLK   (clk),
         .AXIS_ARESETN(rst_n),
         .ENABLE      (enable),
         .s_axis      (sIf),
         .m_axis      (mIf)
      );

      assign mValidW[g] = mIf.TVALID;
      assign mLastW[g]  = mIf.TLAST;
      assign mDataW[g]  = mIf.TDATA;
      assign mUserW[g]  = mIf.TUSER;
      assign mReadyW[g] = mIf.TREADY;
      assign sReadyW[g] = sIf.TREADY;

      // Source 1,2,3,... advancing on each accepted sample; random sink ready.
      initial begin
         int unsigned nextSample;
         bit accNow;
         nextSample = 1;
         sIf.TVALID = 1'b0;
         sIf.TDATA  = DW'(nextSample);
         sIf.TUSER  = '0;
         sIf.TLAST  = 1'b0;
         mIf.TREADY = 1'b0;
         forever begin
            @(negedge clk);
            accNow = sIf.TVALID && sIf.TREADY;
            @(posedge clk);
            #1;
            if (accNow) nextSample++;
            sIf.TVALID = ($urandom_range(99) < sValidPct);
            sIf.TDATA  = DW'(nextSample);
            mIf.TREADY = ($urandom_range(99) < mReadyPct);
         end
      end

      // Reference model + monitor: a frame is the last WIN accepted samples,
      // due once WIN fresh (after reset/disable) or HOP further samples arrive.
      initial begin
         beat_t       expQ[$];
         int unsigned hist[$];
         beat_t       e;
         string       tag;
         int          run, need, frameCycles, lat, sinceReset;
         bit          inFrame, outBusy, prevStall, latActive, allReady, sAcc, mPop, prevLast;
         int unsigned prevData, prevUser;
         tag = $sformatf("hop%0d", HOP);
         need = WIN;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               expQ.delete();
               run = 0; need = WIN; inFrame = 0; outBusy = 0; prevStall = 0;
               latActive = 0; sinceReset = 0;
            end else begin
               sAcc = sIf.TVALID && sIf.TREADY;
               mPop = mIf.TVALID && mIf.TREADY;
               if (sinceReset < 1000) sinceReset++;

               if (sinceReset == 1) checkOutput({tag, " s_ready after release"}, sIf.TREADY, 0);
               else if (inFrame) checkOutput({tag, " s_ready low in frame"}, sIf.TREADY, 0);
               else checkOutput({tag, " s_ready outside frame"}, sIf.TREADY, 1);

               if (outBusy) checkOutput({tag, " tvalid held mid-frame"}, mIf.TVALID, 1);
               if (prevStall) begin
                  checkOutput({tag, " tdata stable"}, mIf.TDATA, prevData);
                  checkOutput({tag, " tuser stable"}, mIf.TUSER, prevUser);
                  checkOutput({tag, " tlast stable"}, mIf.TLAST, prevLast);
               end
               if (mPop) begin
                  checkOutput({tag, " beat expected"}, (expQ.size() > 0), 1);
                  if (expQ.size() > 0) begin
                     e = expQ.pop_front();
                     checkOutput({tag, " frame tdata"}, mIf.TDATA, e.data);
                     checkOutput({tag, " frame tuser"}, mIf.TUSER, e.user);
                     checkOutput({tag, " frame tlast"}, mIf.TLAST, e.last);
                  end
               end
               prevStall = mIf.TVALID && !mIf.TREADY;
               prevData  = mIf.TDATA;
               prevUser  = mIf.TUSER;
               prevLast  = mIf.TLAST;
               if (mPop && mIf.TLAST) outBusy = 0;
               else if (mIf.TVALID) outBusy = 1;

               if (latActive) begin
                  lat++;
                  if (mIf.TVALID || lat > 10) begin
                     checkOutput({tag, " first tvalid latency"}, lat, 3);
                     latActive = 0;
                  end
               end

               if (sAcc) begin
                  hist.push_back(sIf.TDATA);
                  if (hist.size() > WIN) void'(hist.pop_front());
               end

               if (inFrame) begin
                  frameCycles++;
                  allReady &= mIf.TREADY;
                  if (mPop && mIf.TLAST) begin
                     if (allReady) checkOutput({tag, " frame duration"}, frameCycles, WIN + 2);
                     inFrame = 0;
                     run = 0;
                     need = enable ? HOP : WIN;
                  end
               end else if (!enable) begin
                  run = 0;
                  need = WIN;
               end else if (sAcc) begin
                  run++;
                  if (run == need) begin
                     for (int k = 0; k < WIN; k++) begin
                        e.data = hist[hist.size() - WIN + k];
                        e.user = k;
                        e.last = (k == WIN - 1);
                        expQ.push_back(e);
                     end
                     inFrame = 1; frameCycles = 0; allReady = 1; lat = 0; latActive = 1;
                  end
               end
            end
            pending[g] = expQ.size();
         end
      end
   end

   initial begin
      @(posedge clk);
      #2;
      checkOutput("reset tvalid", mValidW[0], 0);
      checkOutput("reset tdata", mDataW[0], 0);
      checkOutput("reset tuser", mUserW[0], 0);
      checkOutput("reset tlast", mLastW[0], 0);
      checkOutput("reset s_ready", sReadyW[0], 0);
      checkOutput("reset s_ready hop8", sReadyW[1], 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      applyStimulus(60, 100, 100, 1);
      applyStimulus(300, 70, 50, 1);
      applyStimulus(40, 100, 100, 1);

      waitBeat(2, 1, "reach beat 3 for enable drop");
      @(posedge clk);
      #1 enable = 1'b0;
      waitBeat(WIN - 1, 1, "frame completes after enable drop");
      @(posedge clk);
      #1;
      applyStimulus(15, 100, 100, 0);
      applyStimulus(60, 100, 100, 1);

      waitBeat(4, 0, "reach beat 5 for reset");
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid-frame reset tvalid", mValidW[0], 0);
      checkOutput("mid-frame reset tdata", mDataW[0], 0);
      checkOutput("mid-frame reset tuser", mUserW[0], 0);
      checkOutput("mid-frame reset tlast", mLastW[0], 0);
      checkOutput("mid-frame reset s_ready", sReadyW[0], 0);
      checkOutput("mid-frame reset tvalid hop8", mValidW[1], 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(60, 100, 100, 1);

      for (int i = 0; i < 20; i++) applyStimulus(20, 80, 60, ($urandom_range(3) != 0));
      applyStimulus(60, 0, 100, 1);

      checkOutput("leftover beats hop4", pending[0], 0);
      checkOutput("leftover beats hop8", pending[1], 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
